// File: rtl/sfilt_pkg.sv
// Shared definitions for the FIR sequencer and the multiply-accumulate filter datapath.
package sfilt_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHIFT_W = 7;

    localparam logic [1:0] CMD_FIRST = 2'd0;
    localparam logic [1:0] CMD_MAC   = 2'd1;
    localparam logic [1:0] CMD_SHIFT = 2'd2;
    localparam logic [1:0] CMD_OUT   = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StShift,
        StFlush
    } seq_state_e;

endpackage

// File: rtl/sfilt_seq_dline.sv
// Circular sample delay line: one write per accepted sample, pointer advance at end of pass,
// combinational read at a tap offset behind the newest sample.
module sfilt_seq_dline
    import sfilt_pkg::*;
#(
    parameter int unsigned NTAPS = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_adv,
    input  logic [AW-1:0]     i_off,
    output logic [DATA_W-1:0] o_rdata
);

    localparam logic [AW-1:0] NTapsA  = AW'(NTAPS);
    localparam logic [AW-1:0] LastIdx = AW'(NTAPS - 1);

    logic [DATA_W-1:0] r_buf [NTAPS];
    logic [AW-1:0]     r_wp;
    logic [AW-1:0]     w_idx;

    // NTAPS need not be a power of two, so wrap by compare rather than by truncation.
    always_comb begin
        if (r_wp >= i_off) begin
            w_idx = r_wp - i_off;
        end else begin
            w_idx = r_wp + NTapsA - i_off;
        end
    end

    assign o_rdata = r_buf[w_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp <= '0;
            for (int i = 0; i < int'(NTAPS); i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (i_we) begin
                r_buf[r_wp] <= i_wdata;
            end
            if (i_adv) begin
                r_wp <= (r_wp == LastIdx) ? '0 : r_wp + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sfilt_seq.sv
// FIR pass sequencer: per accepted sample, issues n multiply commands, one shift/round
// and one output command to the shared MAC filter datapath.
module sfilt_seq
    import sfilt_pkg::*;
#(
    parameter int unsigned NTAPS = 16,
    parameter int unsigned AW    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_push,
    input  logic [DATA_W-1:0]  s_data,
    output logic               s_ready,
    input  logic               coef_we,
    input  logic [AW-1:0]      coef_addr,
    input  logic [DATA_W-1:0]  coef_wdata,
    input  logic [AW:0]        ntaps_cfg,
    input  logic [SHIFT_W-1:0] shift_cfg,
    output logic               f_pushin,
    output logic [1:0]         f_cmd,
    output logic [DATA_W-1:0]  f_q,
    output logic [DATA_W-1:0]  f_h,
    output logic               busy,
    output logic               cfg_err
);

    localparam logic [AW:0] NTapsW = (AW + 1)'(NTAPS);

    seq_state_e         r_state;
    logic [AW-1:0]      r_k;
    logic [AW-1:0]      r_last;
    logic [SHIFT_W-1:0] r_sh;
    logic               r_pushin;
    logic [1:0]         r_cmd;
    logic [DATA_W-1:0]  r_q;
    logic [DATA_W-1:0]  r_h;
    logic               r_cfg_err;
    logic [DATA_W-1:0]  r_coef [NTAPS];

    logic               w_idle;
    logic               w_accept;
    logic               w_coef_wr;
    logic [AW:0]        w_n;
    logic [AW-1:0]      w_last;
    logic [AW-1:0]      w_off;
    logic [DATA_W-1:0]  w_rdata;
    logic [DATA_W-1:0]  w_coef0;

    assign w_idle    = (r_state == StIdle);
    assign w_accept  = s_push && w_idle;
    assign w_coef_wr = coef_we && w_idle && !rst && ({1'b0, coef_addr} < NTapsW);
    assign w_off     = r_k + 1'b1;

    always_comb begin
        if (ntaps_cfg == '0) begin
            w_n = (AW + 1)'(1);
        end else if (ntaps_cfg > NTapsW) begin
            w_n = NTapsW;
        end else begin
            w_n = ntaps_cfg;
        end
        w_last = AW'(w_n - 1'b1);
    end

    // A write to coef[0] on the acceptance edge must already be seen by tap 0.
    assign w_coef0 = (w_coef_wr && coef_addr == '0) ? coef_wdata : r_coef[0];

    sfilt_seq_dline #(
        .NTAPS (NTAPS),
        .AW    (AW)
    ) u_dline (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_accept),
        .i_wdata (s_data),
        .i_adv   (r_state == StFlush),
        .i_off   (w_off),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (w_coef_wr) begin
            r_coef[coef_addr] <= coef_wdata;
        end
    end

    // Outputs are loaded one edge ahead so that they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_k       <= '0;
            r_last    <= '0;
            r_sh      <= '0;
            r_pushin  <= 1'b0;
            r_cmd     <= CMD_FIRST;
            r_q       <= '0;
            r_h       <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            if (coef_we && !w_idle) begin
                r_cfg_err <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    r_pushin <= 1'b0;
                    r_cmd    <= CMD_FIRST;
                    r_q      <= '0;
                    r_h      <= '0;
                    if (s_push) begin
                        r_state  <= StMac;
                        r_k      <= '0;
                        r_last   <= w_last;
                        r_sh     <= shift_cfg;
                        r_pushin <= 1'b1;
                        r_q      <= s_data;
                        r_h      <= w_coef0;
                    end
                end
                StMac: begin
                    if (r_k == r_last) begin
                        r_state <= StShift;
                        r_cmd   <= CMD_SHIFT;
                        r_q     <= '0;
                        r_h     <= {{(DATA_W - SHIFT_W){1'b0}}, r_sh};
                    end else begin
                        r_k   <= w_off;
                        r_cmd <= CMD_MAC;
                        r_q   <= w_rdata;
                        r_h   <= r_coef[w_off];
                    end
                end
                StShift: begin
                    r_state <= StFlush;
                    r_cmd   <= CMD_OUT;
                    r_q     <= '0;
                    r_h     <= '0;
                end
                StFlush: begin
                    r_state  <= StIdle;
                    r_pushin <= 1'b0;
                    r_cmd    <= CMD_FIRST;
                    r_q      <= '0;
                    r_h      <= '0;
                end
            endcase
        end
    end

    assign s_ready  = w_idle;
    assign busy     = !w_idle;
    assign f_pushin = r_pushin;
    assign f_cmd    = r_cmd;
    assign f_q      = r_q;
    assign f_h      = r_h;
    assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_sfilt_seq.sv
// Directed bench for sfilt_seq: scoreboard of expected filter commands plus a behavioural
// MAC filter that turns the observed command stream into filter results.
module tb_sfilt_seq;
    import sfilt_pkg::*;

    localparam int NTAPS = 16;
    localparam int AW    = 4;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] q;
        logic [31:0] h;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_push = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_ready;
    logic        coef_we = 1'b0;
    logic [3:0]  coef_addr = '0;
    logic [31:0] coef_wdata = '0;
    logic [4:0]  ntaps_cfg = '0;
    logic [6:0]  shift_cfg = '0;
    logic        f_pushin;
    logic [1:0]  f_cmd;
    logic [31:0] f_q;
    logic [31:0] f_h;
    logic        busy;
    logic        cfg_err;

    cmd_t        exp_q[$];
    int          obs_z[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          m_cnt = 0;
    int          m_wp = 0;
    logic [31:0] m_buf [NTAPS];
    logic [31:0] m_coef [NTAPS];
    logic        m_err = 1'b0;
    longint      f_acc = 0;

    always #5 clk = ~clk;

    sfilt_seq #(
        .NTAPS (NTAPS),
        .AW    (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_push     (s_push),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .ntaps_cfg  (ntaps_cfg),
        .shift_cfg  (shift_cfg),
        .f_pushin   (f_pushin),
        .f_cmd      (f_cmd),
        .f_q        (f_q),
        .f_h        (f_h),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour at a rising edge, using the inputs that were stable before it.
    task automatic model_edge();
        cmd_t e;
        int   n;
        if (rst) begin
            exp_q.delete();
            m_cnt = 0;
            m_wp  = 0;
            m_err = 1'b0;
            for (int i = 0; i < NTAPS; i++) m_buf[i] = '0;
        end else begin
            if (coef_we) begin
                if (m_cnt != 0) m_err = 1'b1;
                else if (int'(coef_addr) < NTAPS) m_coef[coef_addr] = coef_wdata;
            end
            if (s_push && m_cnt == 0) begin
                m_buf[m_wp] = s_data;
                n = int'(ntaps_cfg);
                if (n == 0) n = 1;
                if (n > NTAPS) n = NTAPS;
                for (int k = 0; k < n; k++) begin
                    e.cmd = (k == 0) ? CMD_FIRST : CMD_MAC;
                    e.q   = m_buf[(m_wp + NTAPS - k) % NTAPS];
                    e.h   = m_coef[k];
                    exp_q.push_back(e);
                end
                e.cmd = CMD_SHIFT; e.q = '0; e.h = {25'b0, shift_cfg};
                exp_q.push_back(e);
                e.cmd = CMD_OUT; e.q = '0; e.h = '0;
                exp_q.push_back(e);
                m_cnt = n + 2;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_wp = (m_wp + 1) % NTAPS;
            end
        end
    endtask

    task automatic check_outputs();
        cmd_t e;
        int   sh;
        chk("s_ready", 32'(s_ready), 32'(m_cnt == 0));
        chk("busy", 32'(busy), 32'(m_cnt != 0));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        chk("f_pushin", 32'(f_pushin), 32'(m_cnt != 0));
        if (m_cnt != 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("f_cmd", 32'(f_cmd), 32'(e.cmd));
            chk("f_q", f_q, e.q);
            chk("f_h", f_h, e.h);
        end else begin
            chk("f_cmd_idle", 32'(f_cmd), 32'd0);
            chk("f_q_idle", f_q, 32'd0);
            chk("f_h_idle", f_h, 32'd0);
        end
        if (f_pushin === 1'b1) begin
            case (f_cmd)
                CMD_FIRST: f_acc = longint'($signed(f_q)) * longint'($signed(f_h));
                CMD_MAC:   f_acc = f_acc + longint'($signed(f_q)) * longint'($signed(f_h));
                CMD_SHIFT: begin
                    sh = int'(f_h[6:0]);
                    if (sh > 0) f_acc = (f_acc + (64'sd1 <<< (sh - 1))) >>> sh;
                end
                default:   obs_z.push_back(int'(f_acc[31:0]));
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic wcoef(input int a, input int d);
        coef_we    = 1'b1;
        coef_addr  = 4'(a);
        coef_wdata = 32'(d);
        tick();
        coef_we    = 1'b0;
    endtask

    task automatic send(input int d, input int nt, input int sh);
        bit done = 1'b0;
        s_push    = 1'b1;
        s_data    = 32'(d);
        ntaps_cfg = 5'(nt);
        shift_cfg = 7'(sh);
        for (int i = 0; i < 64 && !done; i++) begin
            if (m_cnt == 0) done = 1'b1;
            tick();
        end
        s_push = 1'b0;
        chk("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && m_cnt != 0; i++) tick();
    endtask

    task automatic expect_z(input string tag, input int v);
        logic [31:0] got = 'x;
        if (obs_z.size() > 0) got = 32'(obs_z.pop_front());
        chk(tag, got, 32'(v));
    endtask

    initial begin
        int lo;
        int sum;
        for (int i = 0; i < NTAPS; i++) m_coef[i] = '0;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        wcoef(0, 3);
        wcoef(1, 5);
        send(10, 2, 1); wait_idle(); expect_z("z_pass1", 15);
        send(20, 2, 1); wait_idle(); expect_z("z_pass2", 55);

        rst = 1'b1; tick(); rst = 1'b0;
        send(10, 2, 2); wait_idle(); expect_z("z_round1", 8);
        send(20, 2, 2); wait_idle(); expect_z("z_round2", 28);

        rst = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < NTAPS; k++) wcoef(k, 1);
        for (int i = 1; i <= 20; i++) begin
            lo  = (i > 16) ? i - 15 : 1;
            sum = (lo + i) * (i - lo + 1) / 2;
            send(i, 16, 0);
            wait_idle();
            expect_z("z_wrap", sum);
        end
        send(21, 0, 0);  wait_idle(); expect_z("z_clamp_lo", 21);
        send(22, 31, 0); wait_idle(); expect_z("z_clamp_hi", 232);

        // Coefficient write and extra sample while a pass is running.
        send(23, 16, 0);
        coef_we    = 1'b1;
        coef_addr  = 4'd0;
        coef_wdata = 32'd99;
        s_push     = 1'b1;
        s_data     = 32'd999;
        tick();
        tick();
        coef_we = 1'b0;
        s_push  = 1'b0;
        wait_idle(); expect_z("z_busy_write", 248);
        chk("no_extra_pass", 32'(obs_z.size()), 32'd0);
        send(24, 16, 0); wait_idle(); expect_z("z_coef_kept", 264);

        rst = 1'b1; tick(); rst = 1'b0;
        wcoef(0, 2);
        send(50, 16, 0);
        tick();
        tick();
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        tick();
        chk("z_after_abort", 32'(obs_z.size()), 32'd0);
        send(7, 1, 0); wait_idle(); expect_z("z_after_rst", 14);
        send(1, 3, 0); wait_idle(); expect_z("z_dline_clear", 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
